// File: rtl/bus_sram_target.sv
// Bus target that maps a word-addressed window at Base onto an external
// synchronous single-port SRAM. It serves single and burst reads and writes.
// All bus outputs stay at zero unless this target is driving them, so several
// targets can share the bus through an OR.
module bus_sram_target #(
  parameter logic [31:0] Base      = 32'h50000000,
  parameter int          AddrWidth = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          address_dataIN,
  input  logic [3:0]           byte_enableIN,
  input  logic [7:0]           burst_sizeIN,
  input  logic                 read_n_writeIN,
  input  logic                 begin_transactionIN,
  input  logic                 end_transactionIN,
  input  logic                 data_validIN,
  input  logic                 busyIN,
  input  logic                 errorIN,
  output logic [31:0]          address_dataOUT,
  output logic                 end_transactionOUT,
  output logic                 data_validOUT,
  output logic                 busyOUT,
  output logic                 errorOUT,
  output logic [AddrWidth-1:0] memAddress,
  output logic [31:0]          memDataIn,
  output logic                 memWriteEnable,
  output logic [3:0]           memByteEnable,
  input  logic [31:0]          memDataOut
);

  localparam int          TagLo  = AddrWidth + 2;
  localparam logic [31:0] MaxIdx = (32'd1 << AddrWidth) - 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_DATA,
    READ_FETCH,
    READ_DATA,
    READ_END,
    ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [8:0]           cnt_q, cnt_d;     // one bit wider than burst so the count past the last beat fits
  logic [7:0]           burst_q, burst_d;
  logic [3:0]           be_q, be_d;

  logic        hit;
  logic [31:0] last_idx;
  logic        out_of_range;
  logic        last_beat;
  logic        wr_beat;

  // The tag compare ignores byte-offset bits; the range check uses 32-bit math so the sum cannot wrap.
  assign hit          = begin_transactionIN && (address_dataIN[31:TagLo] == Base[31:TagLo]);
  assign last_idx     = 32'(address_dataIN[AddrWidth+1:2]) + 32'(burst_sizeIN);
  assign out_of_range = last_idx > MaxIdx;
  assign last_beat    = cnt_q == {1'b0, burst_q};
  assign wr_beat      = (state_q == WRITE_DATA) && data_validIN && !errorIN &&
                        (cnt_q <= {1'b0, burst_q});

  // Next-state, transaction capture and beat/index advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    be_d    = be_q;
    if (errorIN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            idx_d   = address_dataIN[AddrWidth+1:2];
            be_d    = byte_enableIN;
            burst_d = burst_sizeIN;
            cnt_d   = '0;
            if (out_of_range)        state_d = ERROR;
            else if (read_n_writeIN) state_d = READ_FETCH;
            else                     state_d = WRITE_DATA;
          end
        end
        WRITE_DATA: begin
          if (wr_beat) begin
            cnt_d = cnt_q + 9'd1;
            // Stop the index at the final word so it never steps past the window.
            if (!last_beat) idx_d = idx_q + AddrWidth'(1);
          end
          if (end_transactionIN) state_d = IDLE;
        end
        READ_FETCH: state_d = READ_DATA;
        READ_DATA: begin
          if (!busyIN) begin
            if (last_beat) begin
              state_d = READ_END;
            end else begin
              idx_d   = idx_q + AddrWidth'(1);
              cnt_d   = cnt_q + 9'd1;
              state_d = READ_FETCH;
            end
          end
        end
        READ_END: state_d = IDLE;
        ERROR:    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Bus and SRAM outputs; everything is zero unless the current state drives it, and an abort silences all.
  always_comb begin
    address_dataOUT    = '0;
    end_transactionOUT = 1'b0;
    data_validOUT      = 1'b0;
    errorOUT           = 1'b0;
    memAddress         = '0;
    memDataIn          = '0;
    memWriteEnable     = 1'b0;
    memByteEnable      = '0;
    if (!errorIN) begin
      case (state_q)
        WRITE_DATA: begin
          memAddress = idx_q;
          if (wr_beat) begin
            memWriteEnable = 1'b1;
            memDataIn      = address_dataIN;
            memByteEnable  = be_q;
          end
        end
        READ_FETCH: memAddress = idx_q;
        READ_DATA: begin
          memAddress      = idx_q;
          data_validOUT   = 1'b1;
          address_dataOUT = memDataOut;
        end
        READ_END: end_transactionOUT = 1'b1;
        ERROR:    errorOUT = 1'b1;
        default: ;
      endcase
    end
  end

  assign busyOUT = 1'b0;

  // State and transaction registers; reset clears them immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      be_q    <= be_d;
    end
  end

endmodule
